// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data-cache responder:
// default geometry, address slicing constants and FSM state encoding.
package dcache_pkg;

  localparam int unsigned DC_ADDR_W  = 10;
  localparam int unsigned DC_DATA_W  = 32;
  localparam int unsigned DC_INDEX_W = 5;
  localparam int unsigned DC_CNT_W   = 16;

  // Word address = {tag, index}; the index occupies the low bits.
  localparam int unsigned DC_INDEX_LSB = 0;
  localparam int unsigned DC_TAG_LSB   = DC_INDEX_W;
  localparam int unsigned DC_TAG_W     = DC_ADDR_W - DC_INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays with a combinational
// lookup port and a synchronous fill/update write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = DC_INDEX_W,
  parameter int unsigned TAG_W   = DC_TAG_W,
  parameter int unsigned DATA_W  = DC_DATA_W
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hit,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic               wr_fill,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en && wr_fill) begin
      valid_d[wr_index] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= wr_data;
      if (wr_fill) begin
        tag_q[wr_index] <= wr_tag;
      end
    end
  end

  always_comb begin
    rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    rd_data = data_q[rd_index];
  end

endmodule

// File: rtl/dcache_wt_responder.sv
// Write-through, no-write-allocate direct-mapped data cache between the core's
// load/store port and a ready-pulse main-memory interface.
module dcache_wt_responder
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W  = DC_ADDR_W,
  parameter int unsigned DATA_W  = DC_DATA_W,
  parameter int unsigned INDEX_W = DC_INDEX_W,
  parameter int unsigned CNT_W   = DC_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              Stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  dc_state_e         state_q, state_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [DATA_W-1:0]  lk_data;

  logic               ls_wr_en;
  logic               ls_wr_fill;
  logic [INDEX_W-1:0] ls_wr_index;
  logic [TAG_W-1:0]   ls_wr_tag;
  logic [DATA_W-1:0]  ls_wr_data;

  logic [DATA_W-1:0]  rd_data;
  logic               stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lk_index = Addr[INDEX_W-1:0];
  assign lk_tag   = Addr[ADDR_W-1:INDEX_W];

  dcache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_line_store (
    .clk      (CLK),
    .clr_n    (RST),
    .rd_index (lk_index),
    .rd_tag   (lk_tag),
    .rd_hit   (lk_hit),
    .rd_data  (lk_data),
    .wr_en    (ls_wr_en && RST),
    .wr_fill  (ls_wr_fill),
    .wr_index (ls_wr_index),
    .wr_tag   (ls_wr_tag),
    .wr_data  (ls_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_rd_en_d  = mem_rd_en_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    rd_data      = '0;
    stall        = 1'b0;
    ls_wr_en     = 1'b0;
    ls_wr_fill   = 1'b0;
    ls_wr_index  = lk_index;
    ls_wr_tag    = lk_tag;
    ls_wr_data   = WD;

    case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load and leaves the counters alone.
        if (MemWrite) begin
          stall       = 1'b1;
          mem_addr_d  = Addr;
          mem_wdata_d = WD;
          mem_wr_en_d = 1'b1;
          state_d     = ST_WR_THRU;
          ls_wr_en    = lk_hit;
        end else if (MemRead) begin
          if (lk_hit) begin
            rd_data     = lk_data;
            hit_count_d = sat_inc(hit_count_q);
          end else begin
            stall        = 1'b1;
            mem_addr_d   = Addr;
            mem_rd_en_d  = 1'b1;
            state_d      = ST_RD_MISS;
            miss_count_d = sat_inc(miss_count_q);
          end
        end else begin
          stall = 1'b0;
        end
      end
      ST_RD_MISS: begin
        if (mem_ready) begin
          rd_data     = mem_rdata;
          mem_rd_en_d = 1'b0;
          state_d     = ST_IDLE;
          ls_wr_en    = 1'b1;
          ls_wr_fill  = 1'b1;
          ls_wr_index = mem_addr_q[INDEX_W-1:0];
          ls_wr_tag   = mem_addr_q[ADDR_W-1:INDEX_W];
          ls_wr_data  = mem_rdata;
        end else begin
          stall = 1'b1;
        end
      end
      ST_WR_THRU: begin
        if (mem_ready) begin
          mem_wr_en_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign RD         = rd_data;
  assign Stall      = stall;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
